// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits resolved CW=WIDTH/STAGES bits per cycle.
// Optional macro PIPE_RIPPLE_ADDER_OVF_EN enables the registered signed-overflow flag.
module pipe_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  endfunction

  // Registers after each stage; element LAST of the data arrays is never consumed
  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];

  // Per-stage combinational view: operands entering stage k and its chunk result
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_s   [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];
  logic [CW:0]      st_r   [STAGES];
  logic [WIDTH-1:0] st_nxt [STAGES];

  always_comb begin
    st_a[0] = a;
    st_b[0] = op_sub ? ~b : b;
    st_s[0] = '0;
    st_c[0] = op_sub | cin;
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_p[k-1];
      st_b[k] = b_p[k-1];
      st_s[k] = s_p[k-1];
      st_c[k] = c_p[k-1];
      st_v[k] = vld_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      st_r[k]   = add_chunk(st_a[k][k*CW +: CW], st_b[k][k*CW +: CW], st_c[k]);
      st_nxt[k] = st_s[k];
      st_nxt[k][k*CW +: CW] = st_r[k][CW-1:0];
    end
  end

  // Stage registers: data is free-running, bubbles carry don't-care contents
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      a_p[k] <= st_a[k];
      b_p[k] <= st_b[k];
      s_p[k] <= st_nxt[k];
      c_p[k] <= st_r[k][CW];
    end
  end

  // Valid shift and output stage; outputs hold their last valid result across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      if (st_v[LAST]) begin
        sum  <= st_nxt[LAST];
        cout <= st_r[LAST][CW];
      end
    end
  end

  assign out_valid = vld_p[LAST];

`ifdef PIPE_RIPPLE_ADDER_OVF_EN
  logic msb_cin;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits
  assign msb_cin = st_nxt[LAST][WIDTH-1] ^ st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (st_v[LAST])
      ovf <= msb_cin ^ st_r[LAST][CW];
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed/streaming bench for pipe_ripple_adder at STAGES=4, plus STAGES=1 and STAGES=16 instances.
module tb_pipe_ripple_adder;

`ifdef PIPE_RIPPLE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0, op_sub = 1'b0;

  logic        out_valid, cout, ovf;
  logic [15:0] sum;
  logic        out_valid1, cout1, ovf1;
  logic [15:0] sum1;
  logic        out_valid16, cout16, ovf16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] last_sum;
  logic        last_cout, last_ovf;

  always #5 clk = ~clk;

  pipe_ripple_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf));

  pipe_ripple_adder #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  pipe_ripple_adder #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sub);
    logic [15:0] ye;
    logic        c0;
    logic [16:0] f;
    logic        o;
    ye = sub ? ~y : y;
    c0 = sub ? 1'b1 : ci;
    f  = {1'b0, x} + {1'b0, ye} + {16'd0, c0};
    o  = (x[15] == ye[15]) && (f[15] != x[15]);
    return {o & OVF_ON, f};
  endfunction

  task automatic drive_op(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sub);
    in_valid = 1'b1; a = x; b = y; cin = ci; op_sub = sub;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_vld: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h want 0000", sum); else n_pass++;
    n_checks++; if ({cout, ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {cout, ovf}); else n_pass++;
    n_checks++; if ({out_valid1, out_valid16} !== 2'b00) $display("FAIL reset_vld_cfg: got %b want 00", {out_valid1, out_valid16}); else n_pass++;
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
  endtask

  task automatic test_add_carry();
    @(negedge clk);
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drive_idle();
      if (i < 4) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_early_vld cyc%0d: got %b want 0", i, out_valid); else n_pass++;
      end else begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL add_vld: got %b want 1", out_valid); else n_pass++;
        n_checks++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000})
          $display("FAIL add_carry: got ovf=%b cout=%b sum=%h want 0 1 0000", ovf, cout, sum); else n_pass++;
      end
    end
    last_sum = 16'h0000; last_cout = 1'b1; last_ovf = 1'b0;
  endtask

  task automatic test_sub();
    @(negedge clk);
    drive_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    @(negedge clk);
    drive_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) drive_idle();
      if (i == 4) begin
        n_checks++; if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE})
          $display("FAIL sub_borrow: got v=%b ovf=%b cout=%b sum=%h want 1 0 0 fffe", out_valid, ovf, cout, sum); else n_pass++;
      end else if (i == 5) begin
        n_checks++; if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b1, 16'h0002})
          $display("FAIL sub_noborrow: got v=%b ovf=%b cout=%b sum=%h want 1 0 1 0002", out_valid, ovf, cout, sum); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++; if ({out_valid, sum, cout} !== {1'b0, 16'h0002, 1'b1})
      $display("FAIL sub_hold: got v=%b sum=%h cout=%b want 0 0002 1", out_valid, sum, cout); else n_pass++;
    last_sum = 16'h0002; last_cout = 1'b1; last_ovf = 1'b0;
  endtask

  task automatic test_ovf();
    @(negedge clk);
    drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drive_idle();
    end
    n_checks++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h8000})
      $display("FAIL ovf_sum: got v=%b cout=%b sum=%h want 1 0 8000", out_valid, cout, sum); else n_pass++;
    n_checks++; if (ovf !== OVF_ON) $display("FAIL ovf_flag: got %b want %b", ovf, OVF_ON); else n_pass++;
    last_sum = 16'h8000; last_cout = 1'b0; last_ovf = OVF_ON;
  endtask

  task automatic test_boundary();
    @(negedge clk);
    drive_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        drive_idle();
        n_checks++; if ({out_valid1, cout1, sum1, ovf1} !== {1'b1, 1'b1, 16'h0000, 1'b0})
          $display("FAIL stages1: got v=%b cout=%b sum=%h ovf=%b want 1 1 0000 0", out_valid1, cout1, sum1, ovf1); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if ({out_valid, cout, sum, ovf} !== {1'b1, 1'b1, 16'h0000, 1'b0})
          $display("FAIL stages4_alt: got v=%b cout=%b sum=%h ovf=%b want 1 1 0000 0", out_valid, cout, sum, ovf); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (out_valid16 !== 1'b0) $display("FAIL stages16_early: got %b want 0", out_valid16); else n_pass++;
      end
      if (i == 16) begin
        n_checks++; if ({out_valid16, cout16, sum16, ovf16} !== {1'b1, 1'b1, 16'h0000, 1'b0})
          $display("FAIL stages16: got v=%b cout=%b sum=%h ovf=%b want 1 1 0000 0", out_valid16, cout16, sum16, ovf16); else n_pass++;
      end
    end
    last_sum = 16'h0000; last_cout = 1'b1; last_ovf = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        ev [200];
    logic [17:0] er [200];
    int          issued, last_t, errs;
    logic [15:0] x, y;
    logic        ci, sb;
    issued = 0; last_t = -10; errs = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t >= 4) begin
        if (ev[t-4]) begin
          n_checks++;
          if ({out_valid, ovf, cout, sum} !== {1'b1, er[t-4]}) begin
            $display("FAIL stream t=%0d: got v=%b ovf=%b cout=%b sum=%h want 1 %b %b %h",
                     t - 4, out_valid, ovf, cout, sum, er[t-4][17], er[t-4][16], er[t-4][15:0]);
          end else n_pass++;
          {last_ovf, last_cout, last_sum} = er[t-4];
        end else begin
          n_checks++;
          if ({out_valid, ovf, cout, sum} !== {1'b0, last_ovf, last_cout, last_sum})
            $display("FAIL stream_bubble t=%0d: got v=%b ovf=%b cout=%b sum=%h want 0 %b %b %h",
                     t - 4, out_valid, ovf, cout, sum, last_ovf, last_cout, last_sum);
          else n_pass++;
        end
      end
      if (issued < 64 && $urandom_range(0, 4) != 0) begin
        x = 16'($urandom); y = 16'($urandom);
        ci = 1'($urandom); sb = 1'($urandom);
        if (issued == 0) begin x = 16'h8000; y = 16'h0001; sb = 1'b1; end
        drive_op(x, y, ci, sb);
        ev[t] = 1'b1;
        er[t] = ref_add(x, y, ci, sb);
        issued++;
        last_t = t;
      end else begin
        drive_idle();
        ev[t] = 1'b0;
        er[t] = '0;
      end
      if (issued == 64 && t >= last_t + 4) break;
    end
    if (issued != 64 || last_t < 0) errs++;
    n_checks++; if (errs != 0) $display("FAIL stream_issue: got %0d ops want 64", issued); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); drive_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk); drive_op(16'h3333, 16'h0001, 1'b1, 1'b1);
    @(negedge clk); drive_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b1; drive_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; drive_idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, ovf, cout, sum} !== {1'b0, 1'b0, 1'b0, 16'h0000})
        $display("FAIL rst_flight cyc%0d: got v=%b ovf=%b cout=%b sum=%h want 0 0 0 0000", i, out_valid, ovf, cout, sum);
      else n_pass++;
      @(negedge clk);
    end
    drive_op(16'h1234, 16'h0FFF, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drive_idle();
    end
    n_checks++; if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b1, 16'h0235})
      $display("FAIL rst_recover: got v=%b ovf=%b cout=%b sum=%h want 1 0 1 0235", out_valid, ovf, cout, sum); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_ovf();
    test_boundary();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
